lockin_integrator: RTL and testbench
====================================

Name: lockin_integrator

Overview:
- Downstream stage of the lock-in mixer.
- Consumes the signed in-phase and quadrature products the mixer emits, one pair per start strobe.
- Low-pass filters and decimates them by boxcar integrate-and-dump over 2^LOG2_N accepted samples.
- Emits the mean I and Q once per frame with a one-cycle valid pulse, for the magnitude/phase stage.

Parameters:
- IN_WIDTH, 42: width of signed phase_in/quadrature_in (mixer DATA_WIDTH+SIN_WIDTH).
- LOG2_N, 10: log2 of frame length; N = 2^LOG2_N samples per output; legal range 1..16.

Ports:
- clk  input  1  system clock, all logic rising-edge.
- reset  input  1  asynchronous, active-high; clears all state.
- start  input  1  sample strobe, driven by mixer o_valid; inputs captured when high.
- clear  input  1  synchronous frame restart; discards partial frame.
- phase_in  input  IN_WIDTH  signed in-phase product.
- quadrature_in  input  IN_WIDTH  signed quadrature product.
- i_out  output  IN_WIDTH  signed mean of phase_in over last complete frame.
- q_out  output  IN_WIDTH  signed mean of quadrature_in over last complete frame.
- o_valid  output  1  one-cycle pulse, i_out/q_out updated.
- sample_cnt  output  LOG2_N  samples accepted in current frame.

Behaviour:
- Reset (async, active-high): acc_i, acc_q, sample_cnt, i_out, q_out, o_valid all 0, immediately on assertion; asserting mid-frame discards the partial frame; first sample after release starts a new frame.
- Accumulators acc_i/acc_q: signed, IN_WIDTH+LOG2_N bits; inputs sign-extended; overflow impossible by construction.
- Two states: ACCUM (sample_cnt < N-1 or no start) and DUMP (start high while sample_cnt == N-1), evaluated per cycle.
- start=1, clear=0, sample_cnt < N-1: acc += input (both channels), sample_cnt++.
- start=1, clear=0, sample_cnt == N-1 (Nth sample): next edge i_out = (acc_i + phase_in) >>> LOG2_N, q_out likewise, both truncated to IN_WIDTH; o_valid=1 that cycle; acc_i, acc_q, sample_cnt reset to 0.
- Division is arithmetic shift: rounds toward -inf; result always fits IN_WIDTH.
- Latency: o_valid asserts on the clock edge that captures the Nth sample, i.e. outputs visible in the cycle after Nth start.
- o_valid high exactly one cycle per frame; 0 otherwise. Back-to-back start with no gaps supported; gaps of any length between strobes allowed, no timeout.
- i_out/q_out hold their value between dumps.
- start=0: accumulators, sample_cnt hold.
- clear=1: acc_i, acc_q, sample_cnt to 0 on next edge; i_out, q_out hold; o_valid 0. clear with start in same cycle: clear wins, sample discarded, no dump even if sample_cnt == N-1.
- No backpressure: consumer must take i_out/q_out on o_valid or read held value before next dump.

Test Plan (LOG2_N=2, N=4, IN_WIDTH=42):
- Reset 40 ns, release; four start pulses phase_in=500000, quadrature_in=250000 -> o_valid one cycle after 4th strobe; i_out=500000, q_out=250000; sample_cnt back to 0.
- Four samples phase_in=-500000, quadrature_in=-250000, start every 3rd cycle -> i_out=-500000, q_out=-250000; exactly one o_valid pulse.
- phase_in sequence 1,2,3,-7 (sum -1) -> i_out=-1 (floor); sequence 1,1,1,2 (sum 5) -> i_out=1.
- Four samples of -2^41 on both channels -> i_out=q_out=-2^41; four of 2^41-1 -> 2^41-1; no wrap.
- Two samples of 100, then clear concurrent with a third start -> no o_valid, sample_cnt=0, i_out unchanged; next four samples of 8 -> i_out=8.
- Three samples accepted, assert reset mid-frame for 20 ns -> i_out, q_out, sample_cnt, o_valid = 0 immediately; next four samples of 40 -> i_out=40, o_valid after 4th.

Source files
------------

// File: rtl/lockin_integrator.sv
// lockin_integrator
//   Boxcar integrate-and-dump low-pass/decimator for the lock-in mixer's
//   in-phase and quadrature products. Each start strobe accepts one I/Q pair.
//   After 2^LOG2_N accepted pairs the mean of each channel is presented on
//   i_out/q_out with a one-cycle o_valid pulse, and the frame restarts.
//
// Ports
//   clk            system clock, rising edge
//   reset          asynchronous, active-high; clears all state
//   start          sample strobe (mixer o_valid); inputs captured when high
//   clear          synchronous frame restart; discards the partial frame
//   phase_in       signed in-phase product, IN_WIDTH bits
//   quadrature_in  signed quadrature product, IN_WIDTH bits
//   i_out, q_out   signed frame means, held between dumps
//   o_valid        one-cycle pulse when i_out/q_out update
//   sample_cnt     samples accepted in the current frame
//
// Handshake: start is a valid-only strobe with no ready; every strobe that is
// not overridden by clear is consumed on the edge where it is high. The
// consumer must take i_out/q_out on o_valid or read the held value before the
// next dump.
module lockin_integrator #(
  parameter int IN_WIDTH = 42,
  parameter int LOG2_N   = 10
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       clear,
  input  logic signed [IN_WIDTH-1:0] phase_in,
  input  logic signed [IN_WIDTH-1:0] quadrature_in,
  output logic signed [IN_WIDTH-1:0] i_out,
  output logic signed [IN_WIDTH-1:0] q_out,
  output logic                       o_valid,
  output logic        [LOG2_N-1:0]   sample_cnt
);

  // 2^LOG2_N samples of IN_WIDTH bits cannot exceed IN_WIDTH+LOG2_N bits.
  localparam int ACC_W = IN_WIDTH + LOG2_N;
  localparam logic [LOG2_N-1:0] LAST_CNT = '1;  // N-1

  // Per-cycle operating phase; not a stored state, derived from inputs+count.
  typedef enum logic {ACCUM, DUMP} phase_e;
  phase_e phase;

  logic signed [ACC_W-1:0]    acc_i_q, acc_i_d;
  logic signed [ACC_W-1:0]    acc_q_q, acc_q_d;
  logic        [LOG2_N-1:0]   cnt_q, cnt_d;
  logic signed [IN_WIDTH-1:0] i_out_q, i_out_d;
  logic signed [IN_WIDTH-1:0] q_out_q, q_out_d;
  logic                       o_valid_q, o_valid_d;

  logic signed [ACC_W-1:0]    ext_i, ext_q;
  logic signed [ACC_W-1:0]    sum_i, sum_q;

  always_comb begin
    ext_i = {{LOG2_N{phase_in[IN_WIDTH-1]}}, phase_in};
    ext_q = {{LOG2_N{quadrature_in[IN_WIDTH-1]}}, quadrature_in};
    sum_i = acc_i_q + ext_i;
    sum_q = acc_q_q + ext_q;
  end

  always_comb begin
    acc_i_d   = acc_i_q;
    acc_q_d   = acc_q_q;
    cnt_d     = cnt_q;
    i_out_d   = i_out_q;
    q_out_d   = q_out_q;
    o_valid_d = 1'b0;
    phase     = ACCUM;

    if (clear) begin
      // clear beats a concurrent start: the sample is dropped, no dump.
      acc_i_d = '0;
      acc_q_d = '0;
      cnt_d   = '0;
    end else if (start) begin
      if (cnt_q == LAST_CNT) begin
        phase     = DUMP;
        // Taking bits [LOG2_N +: IN_WIDTH] of the sum is an arithmetic
        // right shift by LOG2_N (floor division) truncated to IN_WIDTH;
        // the mean of IN_WIDTH-bit values always fits.
        i_out_d   = sum_i[LOG2_N +: IN_WIDTH];
        q_out_d   = sum_q[LOG2_N +: IN_WIDTH];
        o_valid_d = 1'b1;
        acc_i_d   = '0;
        acc_q_d   = '0;
        cnt_d     = '0;
      end else begin
        acc_i_d = sum_i;
        acc_q_d = sum_q;
        cnt_d   = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_i_q   <= '0;
      acc_q_q   <= '0;
      cnt_q     <= '0;
      i_out_q   <= '0;
      q_out_q   <= '0;
      o_valid_q <= 1'b0;
    end else begin
      acc_i_q   <= acc_i_d;
      acc_q_q   <= acc_q_d;
      cnt_q     <= cnt_d;
      i_out_q   <= i_out_d;
      q_out_q   <= q_out_d;
      o_valid_q <= o_valid_d;
    end
  end

  assign i_out      = i_out_q;
  assign q_out      = q_out_q;
  assign o_valid    = o_valid_q;
  assign sample_cnt = cnt_q;

endmodule

// File: tb/tb_lockin_integrator.sv
module tb_lockin_integrator;

  localparam int IN_WIDTH = 42;
  localparam int LOG2_N   = 2;
  localparam int N        = 4;

  logic                       clk;
  logic                       reset;
  logic                       start;
  logic                       clear;
  logic signed [IN_WIDTH-1:0] phase_in;
  logic signed [IN_WIDTH-1:0] quadrature_in;
  logic signed [IN_WIDTH-1:0] i_out;
  logic signed [IN_WIDTH-1:0] q_out;
  logic                       o_valid;
  logic        [LOG2_N-1:0]   sample_cnt;

  int n_vec  = 0;
  int n_fail = 0;
  int n_pulses = 0;

  lockin_integrator #(.IN_WIDTH(IN_WIDTH), .LOG2_N(LOG2_N)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .clear         (clear),
    .phase_in      (phase_in),
    .quadrature_in (quadrature_in),
    .i_out         (i_out),
    .q_out         (q_out),
    .o_valid       (o_valid),
    .sample_cnt    (sample_cnt)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Frame-level view: sum the samples of a frame, and when N have arrived
  // emit floor(sum / N) using integer division with a floor correction.
  longint m_sum_i = 0, m_sum_q = 0;
  longint m_i = 0, m_q = 0;
  int     m_cnt = 0;
  bit     m_valid = 1'b0;

  function automatic longint floor_div(input longint a, input longint n);
    longint r;
    r = a / n;
    if ((a % n != 0) && (a < 0)) r = r - 1;
    return r;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_sum_i = 0; m_sum_q = 0; m_i = 0; m_q = 0; m_cnt = 0; m_valid = 1'b0;
    end else begin
      m_valid = 1'b0;
      if (clear) begin
        m_sum_i = 0; m_sum_q = 0; m_cnt = 0;
      end else if (start) begin
        m_sum_i = m_sum_i + longint'(phase_in);
        m_sum_q = m_sum_q + longint'(quadrature_in);
        m_cnt   = m_cnt + 1;
        if (m_cnt == N) begin
          m_i = floor_div(m_sum_i, N);
          m_q = floor_div(m_sum_q, N);
          m_valid = 1'b1;
          m_sum_i = 0; m_sum_q = 0; m_cnt = 0;
        end
      end
    end
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Compare every cycle, away from the active edge.
  always @(negedge clk) begin
    check("o_valid", longint'(o_valid), longint'(m_valid));
    check("sample_cnt", longint'(sample_cnt), longint'(m_cnt));
    check("i_out", longint'(i_out), m_i);
    check("q_out", longint'(q_out), m_q);
    if (o_valid) n_pulses++;
  end

  // ---------------- driver tasks ----------------
  // All tasks start and end at posedge+1.
  task automatic pulse(input longint p, input longint q);
    start = 1'b1;
    phase_in = IN_WIDTH'(p);
    quadrature_in = IN_WIDTH'(q);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic frame(input longint p, input longint q, input int gap);
    for (int k = 0; k < N; k++) begin
      pulse(p, q);
      if (k != N - 1) idle(gap);
    end
  endtask

  // ---------------- stimulus ----------------
  longint big_neg, big_pos;
  int pulses_before;

  initial begin
    reset = 1'b1; start = 1'b0; clear = 1'b0;
    phase_in = '0; quadrature_in = '0;
    big_neg = -(longint'(1) <<< 41);
    big_pos = (longint'(1) <<< 41) - 1;
    #40;
    check("reset_o_valid", longint'(o_valid), 0);
    check("reset_i_out", longint'(i_out), 0);
    check("reset_cnt", longint'(sample_cnt), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    idle(1);

    // 1: four back-to-back strobes of constant input
    frame(500000, 250000, 0);
    check("t1_valid", longint'(o_valid), 1);
    check("t1_i", longint'(i_out), 500000);
    check("t1_q", longint'(q_out), 250000);
    check("t1_cnt", longint'(sample_cnt), 0);
    idle(1);
    check("t1_valid_drop", longint'(o_valid), 0);
    check("t1_hold", longint'(i_out), 500000);

    // 2: negative input, strobe every 3rd cycle, exactly one pulse
    pulses_before = n_pulses;
    frame(-500000, -250000, 2);
    check("t2_i", longint'(i_out), -500000);
    check("t2_q", longint'(q_out), -250000);
    idle(3);
    check("t2_pulses", longint'(n_pulses - pulses_before), 1);

    // 3: floor rounding
    pulse(1, 0); pulse(2, 0); pulse(3, 0); pulse(-7, 0);
    check("t3_floor_neg", longint'(i_out), -1);
    idle(1);
    pulse(1, 3); pulse(1, 3); pulse(1, 3); pulse(2, 3);
    check("t3_floor_pos", longint'(i_out), 1);
    check("t3_q", longint'(q_out), 3);
    idle(2);

    // 4: extremes, no wrap
    frame(big_neg, big_neg, 0);
    check("t4_min_i", longint'(i_out), big_neg);
    check("t4_min_q", longint'(q_out), big_neg);
    idle(1);
    frame(big_pos, big_pos, 1);
    check("t4_max_i", longint'(i_out), big_pos);
    check("t4_max_q", longint'(q_out), big_pos);
    idle(1);

    // 5: clear concurrent with start discards the frame
    pulse(100, 100); pulse(100, 100);
    clear = 1'b1;
    pulse(100, 100);
    clear = 1'b0;
    check("t5_no_valid", longint'(o_valid), 0);
    check("t5_cnt", longint'(sample_cnt), 0);
    check("t5_i_hold", longint'(i_out), big_pos);
    // clear with the would-be Nth strobe must not dump either
    pulse(5, 5); pulse(5, 5); pulse(5, 5);
    clear = 1'b1;
    pulse(5, 5);
    clear = 1'b0;
    check("t5_clear_last", longint'(o_valid), 0);
    check("t5_cnt2", longint'(sample_cnt), 0);
    frame(8, 8, 0);
    check("t5_i", longint'(i_out), 8);
    idle(1);

    // 6: asynchronous reset mid-frame
    pulse(7, 7); pulse(7, 7); pulse(7, 7);
    check("t6_cnt_pre", longint'(sample_cnt), 3);
    #3 reset = 1'b1;
    #1;
    check("t6_rst_i", longint'(i_out), 0);
    check("t6_rst_q", longint'(q_out), 0);
    check("t6_rst_cnt", longint'(sample_cnt), 0);
    check("t6_rst_valid", longint'(o_valid), 0);
    #19 reset = 1'b0;
    @(posedge clk); #1;
    frame(40, 40, 0);
    check("t6_valid", longint'(o_valid), 1);
    check("t6_i", longint'(i_out), 40);
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
